exp_share_arb: RTL
==================

EXP_SHARE_ARB -- requirements
Module: exp_share_arb

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; DW, default 16, FP16 data width; EXP_LAT, default 40, fixed exp-unit latency in cycles (valid in to valid out).
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  single clock, rising edge;
 rst  in  1  asynchronous, active-high reset;
 req_valid  in  N_REQ  per-requester operand valid;
 req_x  in  N_REQ*DW  per-requester FP16 operand, requester i at bits [i*DW +: DW];
 req_ready  out  N_REQ  one-hot grant, combinational from req_valid and RR pointer;
 exp_valid_o  out  1  operand valid to shared exp unit;
 exp_x_o  out  DW  operand to shared exp unit;
 exp_valid_i  in  1  result valid from exp unit;
 exp_y_i  in  DW  result from exp unit;
 rsp_valid  out  N_REQ  one-hot result strobe, no backpressure;
 rsp_y  out  DW  result data, shared by all requesters;
 idle_o  out  1  no transaction in flight;
 err_o  out  1  sticky tag/valid mismatch flag.

Function
REQ-003 Block SHALL accept at most one request per cycle; handshake = req_valid[i] & req_ready[i].
REQ-004 req_ready SHALL be one-hot or zero; lowest index at or after RR pointer with req_valid set wins.
REQ-005 RR pointer SHALL advance to winner+1 (mod N_REQ) on every accepted request and hold otherwise.
REQ-006 Accepted request at cycle T SHALL drive exp_valid_o=1, exp_x_o=operand at T+1 (registered); exp_x_o SHALL hold its last value when exp_valid_o=0.
REQ-007 Requester id and valid SHALL enter a tag pipeline of depth EXP_LAT aligned with exp_valid_o, so the tag emerges in the cycle exp_valid_i is expected.
REQ-008 On exp_valid_i=1 with a valid tag i, rsp_valid[i] and rsp_y=exp_y_i SHALL be registered at the next edge (total latency EXP_LAT+2 from handshake).
REQ-009 Throughput SHALL be one result per cycle with no bubbles under continuous requests.
REQ-010 Tag valid with exp_valid_i=0, or exp_valid_i=1 with tag invalid, SHALL set err_o (sticky until rst) and SHALL NOT drive rsp_valid.
REQ-011 In-flight counter (width clog2(EXP_LAT+2)+1) SHALL increment on handshake, decrement on tag exit, unchanged when both coincide; idle_o=1 iff counter is zero and no handshake this cycle.
REQ-012 rsp_y SHALL hold its last value when no rsp_valid is asserted.

Reset
REQ-013 rst SHALL asynchronously clear: RR pointer to 0, tag pipeline, in-flight counter, exp_valid_o, exp_x_o, rsp_valid, rsp_y, err_o to 0; idle_o reads 1.
REQ-014 Reset mid-operation SHALL discard all in-flight tags; any exp_valid_i after reset release from pre-reset operands SHALL set err_o.

Configuration
REQ-015 Macro EXP_ARB_PERF_EN SHALL, when defined, add output perf_grant_cnt (N_REQ*32 bits): per-requester saturating 32-bit accepted-request counters, reset to 0; when undefined, the port and counters SHALL be absent and all other behaviour identical.

Structure
REQ-016 Shared package SHALL hold DW default, FP16 constants (H_ZERO=16'h0000, H_ONE=16'h3C00), and a clog2 function.
REQ-017 Tag pipeline SHALL be a sub-module exp_arb_tag_pipe (params DEPTH, TW; in/out valid+tag); arbitration and counters stay in the top.

Verification
REQ-018 Bench SHALL use a behavioural exp model of exactly EXP_LAT latency and cover:
 - Single req0 x=16'h0000 at T -> exp_valid_o at T+1, rsp_valid=4'b0001, rsp_y=16'h3C00 at T+42; idle_o=1 after.
 - All four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, eight consecutive results in the same order, no bubbles.
 - req_valid=4'b1010 with pointer=0 -> grant 1 then 3 then 1; pointer never stops on idle requesters.
 - Model drops one exp_valid_i -> err_o=1 next cycle, stays 1, no rsp_valid for that slot.
 - rst pulse with 10 requests in flight -> all outputs zero immediately; late model results set err_o; new request after release completes normally.
 - EXP_ARB_PERF_EN defined, 5 req2 accepts -> perf_grant_cnt[2]=5, others 0.

Source files
------------

// File: rtl/exp_share_arb_pkg.sv
// Shared constants and helpers for the exp-unit sharing arbiter.
// Latency: n/a (package). Backpressure: n/a.
// FP16 constants and a constant-foldable clog2 used for pointer and counter sizing.
package exp_share_arb_pkg;

    localparam int DW_DEF = 16;

    localparam logic [15:0] H_ZERO = 16'h0000;
    localparam logic [15:0] H_ONE  = 16'h3C00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/exp_arb_tag_pipe.sv
// Fixed-depth delay line carrying requester id + valid alongside the exp unit.
// Latency: DEPTH cycles in to out. Backpressure: none, shifts every cycle.
// Every stage clears on reset so operands issued before reset come back untagged.
module exp_arb_tag_pipe #(
    parameter int DEPTH = 40,
    parameter int TW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [TW-1:0] in_tag,
    output logic          out_vld,
    output logic [TW-1:0] out_tag
);

    logic [DEPTH-1:0] vld_q;
    logic [TW-1:0]    tag_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            tag_q[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/exp_share_arb.sv
// Round-robin arbiter sharing one fixed-latency exp unit among N_REQ requesters.
// Latency: EXP_LAT+2 cycles handshake to rsp_valid. Backpressure: one grant per cycle, none on responses.
// Optional EXP_ARB_PERF_EN adds per-requester saturating grant counters on perf_grant_cnt.
module exp_share_arb
    import exp_share_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DW_DEF,
    parameter int EXP_LAT = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic                exp_valid_o,
    output logic [DW-1:0]       exp_x_o,
    input  logic                exp_valid_i,
    input  logic [DW-1:0]       exp_y_i,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_y,
    output logic                idle_o,
    output logic                err_o
`ifdef EXP_ARB_PERF_EN
    ,
    output logic [N_REQ*32-1:0] perf_grant_cnt
`endif
);

    localparam int IW = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int CW = clog2(EXP_LAT + 2) + 1;

    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    win_idx;
    logic             win_vld;
    logic [IW:0]      cand;
    logic [DW-1:0]    x_sel;
    logic [IW-1:0]    tag_id_q;
    logic             tag_vld;
    logic [IW-1:0]    tag_id;
    logic             rsp_hit;
    logic             tag_err;
    logic [N_REQ-1:0] rsp_hot;
    logic [CW-1:0]    cnt_q;

    // Scan from the pointer with wrap; first valid requester wins.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        cand      = '0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!win_vld && req_valid[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
        if (win_vld) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign x_sel = req_x[win_idx*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            exp_valid_o <= 1'b0;
            exp_x_o     <= '0;
            tag_id_q    <= '0;
        end else begin
            exp_valid_o <= win_vld;
            if (win_vld) begin
                exp_x_o  <= x_sel;
                tag_id_q <= win_idx;
                ptr_q    <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

    // Tag enters alongside exp_valid_o so it exits exactly when the result is due.
    exp_arb_tag_pipe #(
        .DEPTH (EXP_LAT),
        .TW    (IW)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (exp_valid_o),
        .in_tag  (tag_id_q),
        .out_vld (tag_vld),
        .out_tag (tag_id)
    );

    assign rsp_hit = exp_valid_i & tag_vld;
    assign tag_err = exp_valid_i ^ tag_vld;

    always_comb begin
        rsp_hot = '0;
        if (rsp_hit) begin
            rsp_hot[tag_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_y     <= '0;
            err_o     <= 1'b0;
        end else begin
            rsp_valid <= rsp_hot;
            if (rsp_hit) begin
                rsp_y <= exp_y_i;
            end
            if (tag_err) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({win_vld, tag_vld})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign idle_o = (cnt_q == '0) && !win_vld;

`ifdef EXP_ARB_PERF_EN
    logic [31:0] perf_q [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_perf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                perf_q[g] <= '0;
            end else if (req_ready[g] && (perf_q[g] != '1)) begin
                perf_q[g] <= perf_q[g] + 32'd1;
            end
        end
        assign perf_grant_cnt[g*32 +: 32] = perf_q[g];
    end
`endif

endmodule
